// File: rtl/guess_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// guess_pkg : shared state and walk-direction types for guess_fsm_multi
// Rev 1.0
// ---------------------------------------------------------------------------
package guess_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WIN  = 2'd1,
      LOSE = 2'd2
   } state_t;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } dir_t;

endpackage
`default_nettype wire

// File: rtl/guess_fsm_multi_tick_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tick_gen : free-running divider, one-cycle tick every TICK_DIV enabled cycles
// Rev 1.0
// ---------------------------------------------------------------------------
module tick_gen #(
   parameter int TICK_DIV = 25_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int               c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TICK_DIV - 1);
   localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

   logic [c_cnt_w-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         if (r_cnt == c_last) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + c_one;
         end
      end
   end

   assign tick = en & (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/guess_fsm_multi.sv
`default_nettype none
// ---------------------------------------------------------------------------
// guess_fsm_multi : walking-LED button guess game with walk modes and scores
// Rev 1.0
// ---------------------------------------------------------------------------
module guess_fsm_multi
   import guess_pkg::*;
#(
   parameter int N        = 4,
   parameter int TICK_DIV = 25_000_000,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic [N-1:0]     in,
   output logic [N-1:0]     y,
   output logic             win,
   output logic             lose,
   output logic [CNT_W-1:0] win_cnt,
   output logic [CNT_W-1:0] lose_cnt
);

   localparam int                 c_pos_w   = (N > 1) ? $clog2(N) : 1;
   localparam logic [c_pos_w-1:0] c_pos_last = c_pos_w'(N - 1);
   localparam logic [c_pos_w-1:0] c_pos_one  = c_pos_w'(1);
   localparam logic [N-1:0]       c_y_base   = N'(1);
   localparam logic [CNT_W-1:0]   c_cnt_max  = '1;
   localparam logic [CNT_W-1:0]   c_cnt_one  = CNT_W'(1);

   logic [N-1:0]       r_sync1;
   logic [N-1:0]       r_in_s;
   logic [N-1:0]       r_in_p;
   state_t             r_state;
   dir_t               r_dir;
   logic [c_pos_w-1:0] r_pos;
   logic [N-1:0]       r_y;
   logic               r_win;
   logic               r_lose;
   logic [CNT_W-1:0]   r_win_cnt;
   logic [CNT_W-1:0]   r_lose_cnt;

   logic               w_press;
   logic               w_released;
   logic               w_tick;
   logic               w_tick_en;
   logic               w_clr;
   logic [c_pos_w-1:0] w_pos_nxt;
   dir_t               w_dir_nxt;
   logic [N-1:0]       w_y_nxt;

   // Synchroniser and the press-edge history keep running while disabled so
   // that WIN/LOSE can still exit on button release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= '0;
         r_in_s  <= '0;
         r_in_p  <= '0;
      end else begin
         r_sync1 <= in;
         r_in_s  <= r_sync1;
         r_in_p  <= r_in_s;
      end
   end

   assign w_press    = en & (|r_in_s) & ~(|r_in_p);
   assign w_released = ~(|r_in_s);
   assign w_tick_en  = en & (r_state == RUN);
   assign w_clr      = (r_state != RUN) & w_released;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (w_tick_en),
      .clr  (w_clr),
      .tick (w_tick)
   );

   always_comb begin
      w_pos_nxt = r_pos;
      w_dir_nxt = UP;
      if (!mode) begin
         w_pos_nxt = (r_pos == c_pos_last) ? '0 : (r_pos + c_pos_one);
         w_dir_nxt = UP;
      end else if (r_dir == UP) begin
         if (r_pos == c_pos_last) begin
            w_pos_nxt = r_pos - c_pos_one;
            w_dir_nxt = DOWN;
         end else begin
            w_pos_nxt = r_pos + c_pos_one;
            w_dir_nxt = UP;
         end
      end else begin
         if (r_pos == '0) begin
            w_pos_nxt = c_pos_one;
            w_dir_nxt = UP;
         end else begin
            w_pos_nxt = r_pos - c_pos_one;
            w_dir_nxt = DOWN;
         end
      end
      w_y_nxt = c_y_base << w_pos_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= RUN;
         r_dir      <= UP;
         r_pos      <= '0;
         r_y        <= c_y_base;
         r_win      <= 1'b0;
         r_lose     <= 1'b0;
         r_win_cnt  <= '0;
         r_lose_cnt <= '0;
      end else begin
         case (r_state)
            RUN: begin
               if (!mode) begin
                  r_dir <= UP;
               end
               // A press wins over a coincident tick and is judged on the current LED.
               if (w_press) begin
                  if (r_in_s == r_y) begin
                     r_state <= WIN;
                     r_y     <= '1;
                     r_win   <= 1'b1;
                     if (r_win_cnt != c_cnt_max) begin
                        r_win_cnt <= r_win_cnt + c_cnt_one;
                     end
                  end else begin
                     r_state <= LOSE;
                     r_y     <= '0;
                     r_lose  <= 1'b1;
                     if (r_lose_cnt != c_cnt_max) begin
                        r_lose_cnt <= r_lose_cnt + c_cnt_one;
                     end
                  end
               end else if (w_tick) begin
                  r_pos <= w_pos_nxt;
                  r_dir <= w_dir_nxt;
                  r_y   <= w_y_nxt;
               end
            end
            WIN, LOSE: begin
               if (w_released) begin
                  r_state <= RUN;
                  r_pos   <= '0;
                  r_dir   <= UP;
                  r_y     <= c_y_base;
                  r_win   <= 1'b0;
                  r_lose  <= 1'b0;
               end
            end
            default: begin
               r_state <= RUN;
               r_pos   <= '0;
               r_dir   <= UP;
               r_y     <= c_y_base;
               r_win   <= 1'b0;
               r_lose  <= 1'b0;
            end
         endcase
      end
   end

   assign y        = r_y;
   assign win      = r_win;
   assign lose     = r_lose;
   assign win_cnt  = r_win_cnt;
   assign lose_cnt = r_lose_cnt;

endmodule
`default_nettype wire

// File: tb/tb_guess_fsm_multi.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_guess_fsm_multi : directed self-checking bench for guess_fsm_multi
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_guess_fsm_multi;

   localparam int N        = 4;
   localparam int TICK_DIV = 4;
   localparam int CNT_W    = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             mode;
   logic [N-1:0]     in_b;
   logic [N-1:0]     y;
   logic             win;
   logic             lose;
   logic [CNT_W-1:0] win_cnt;
   logic [CNT_W-1:0] lose_cnt;

   int errors = 0;
   int checks = 0;

   guess_fsm_multi #(
      .N        (N),
      .TICK_DIV (TICK_DIV),
      .CNT_W    (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .mode     (mode),
      .in       (in_b),
      .y        (y),
      .win      (win),
      .lose     (lose),
      .win_cnt  (win_cnt),
      .lose_cnt (lose_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_y(input logic [N-1:0] target);
      int n;
      n = 0;
      while (y !== target && n < 64) begin
         step();
         n++;
      end
      checks++;
      if (y !== target) begin
         errors++;
         $display("FAIL wait_y: y=%b required %b", y, target);
      end
   endtask

   task automatic test_reset();
      rst  = 1'b0;
      en   = 1'b0;
      mode = 1'b0;
      in_b = '0;
      repeat (3) step();
      checks++; if (y !== 4'b0001) begin errors++; $display("FAIL reset_y: got %b want 0001", y); end
      checks++; if (win !== 1'b0) begin errors++; $display("FAIL reset_win: got %b want 0", win); end
      checks++; if (lose !== 1'b0) begin errors++; $display("FAIL reset_lose: got %b want 0", lose); end
      checks++; if (win_cnt !== 2'd0) begin errors++; $display("FAIL reset_win_cnt: got %0d want 0", win_cnt); end
      checks++; if (lose_cnt !== 2'd0) begin errors++; $display("FAIL reset_lose_cnt: got %0d want 0", lose_cnt); end
   endtask

   task automatic test_walk_circular();
      logic [N-1:0] base;
      logic [N-1:0] exp_y;
      base = 4'b0001;
      rst  = 1'b1;
      en   = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         exp_y = base << ((k / 4) % 4);
         checks++;
         if (y !== exp_y) begin
            errors++;
            $display("FAIL walk_circ[%0d]: got %b want %b", k, y, exp_y);
         end
      end
      checks++; if ((win | lose) !== 1'b0) begin errors++; $display("FAIL walk_flags: win=%b lose=%b want 0/0", win, lose); end
   endtask

   task automatic test_win();
      wait_y(4'b0100);
      in_b = 4'b0100;
      step();
      step();
      checks++; if (win !== 1'b0 || y !== 4'b0100) begin errors++; $display("FAIL win_latency: win=%b y=%b want 0 0100", win, y); end
      step();
      checks++; if (win !== 1'b1) begin errors++; $display("FAIL win_flag: got %b want 1", win); end
      checks++; if (y !== 4'b1111) begin errors++; $display("FAIL win_y: got %b want 1111", y); end
      checks++; if (win_cnt !== 2'd1) begin errors++; $display("FAIL win_cnt1: got %0d want 1", win_cnt); end
      in_b = '0;
      step();
      step();
      checks++; if (win !== 1'b1) begin errors++; $display("FAIL win_hold: got %b want 1", win); end
      step();
      checks++; if (y !== 4'b0001 || win !== 1'b0) begin errors++; $display("FAIL win_exit: y=%b win=%b want 0001 0", y, win); end
   endtask

   task automatic test_lose();
      wait_y(4'b0010);
      in_b = 4'b0011;
      repeat (3) step();
      checks++; if (lose !== 1'b1 || y !== 4'b0000) begin errors++; $display("FAIL lose_enter: lose=%b y=%b want 1 0000", lose, y); end
      checks++; if (lose_cnt !== 2'd1 || win_cnt !== 2'd1) begin errors++; $display("FAIL lose_cnt: lose_cnt=%0d win_cnt=%0d want 1 1", lose_cnt, win_cnt); end
      repeat (10) step();
      checks++; if (lose !== 1'b1 || y !== 4'b0000) begin errors++; $display("FAIL lose_hold: lose=%b y=%b want 1 0000", lose, y); end
      in_b = '0;
      step();
      step();
      checks++; if (lose !== 1'b1) begin errors++; $display("FAIL lose_release_lat: got %b want 1", lose); end
      step();
      checks++; if (y !== 4'b0001 || lose !== 1'b0) begin errors++; $display("FAIL lose_exit: y=%b lose=%b want 0001 0", y, lose); end
   endtask

   task automatic test_bounce();
      logic [N-1:0] seq [10];
      seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010,
              4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};
      mode = 1'b1;
      for (int i = 0; i < 10; i++) begin
         repeat (4) step();
         checks++;
         if (y !== seq[i]) begin
            errors++;
            $display("FAIL bounce[%0d]: got %b want %b", i, y, seq[i]);
         end
      end
      mode = 1'b0;
      repeat (4) step();
      checks++; if (y !== 4'b1000) begin errors++; $display("FAIL mode_switch_up: got %b want 1000", y); end
      repeat (4) step();
      checks++; if (y !== 4'b0001) begin errors++; $display("FAIL mode_switch_wrap: got %b want 0001", y); end
   endtask

   task automatic test_press_tick();
      logic [CNT_W-1:0] exp_cnt;
      wait_y(4'b1000);
      step();
      in_b = 4'b1000;
      step();
      step();
      checks++; if (y !== 4'b1000 || win !== 1'b0) begin errors++; $display("FAIL coincide_pre: y=%b win=%b want 1000 0", y, win); end
      step();
      checks++; if (win !== 1'b1 || y !== 4'b1111) begin errors++; $display("FAIL coincide_win: win=%b y=%b want 1 1111", win, y); end
      checks++; if (win_cnt !== 2'd2) begin errors++; $display("FAIL coincide_cnt: got %0d want 2", win_cnt); end
      exp_cnt = 2'd2;
      for (int r = 0; r < 3; r++) begin
         in_b = '0;
         repeat (3) step();
         checks++; if (y !== 4'b0001) begin errors++; $display("FAIL sat_exit[%0d]: got %b want 0001", r, y); end
         in_b = 4'b0001;
         repeat (3) step();
         if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
         checks++;
         if (win !== 1'b1 || win_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL sat_win[%0d]: win=%b win_cnt=%0d want 1 %0d", r, win, win_cnt, exp_cnt);
         end
      end
      in_b = '0;
      repeat (3) step();
      checks++; if (y !== 4'b0001 || win !== 1'b0) begin errors++; $display("FAIL sat_final_exit: y=%b win=%b want 0001 0", y, win); end
   endtask

   task automatic test_enable_freeze();
      en = 1'b0;
      repeat (10) step();
      checks++; if (y !== 4'b0001) begin errors++; $display("FAIL en_freeze_y: got %b want 0001", y); end
      in_b = 4'b0010;
      repeat (5) step();
      checks++; if (lose !== 1'b0 || y !== 4'b0001 || lose_cnt !== 2'd1) begin errors++; $display("FAIL en_press_ignored: lose=%b y=%b lose_cnt=%0d want 0 0001 1", lose, y, lose_cnt); end
      in_b = '0;
      repeat (3) step();
      en = 1'b1;
      wait_y(4'b0010);
      checks++; if (win_cnt !== 2'd3 || lose_cnt !== 2'd1) begin errors++; $display("FAIL pre_reset_cnt: win_cnt=%0d lose_cnt=%0d want 3 1", win_cnt, lose_cnt); end
      #3;
      rst = 1'b0;
      #1;
      checks++; if (y !== 4'b0001) begin errors++; $display("FAIL async_reset_y: got %b want 0001", y); end
      checks++; if (win_cnt !== 2'd0 || lose_cnt !== 2'd0) begin errors++; $display("FAIL async_reset_cnt: win_cnt=%0d lose_cnt=%0d want 0 0", win_cnt, lose_cnt); end
      checks++; if (win !== 1'b0 || lose !== 1'b0) begin errors++; $display("FAIL async_reset_flags: win=%b lose=%b want 0 0", win, lose); end
      step();
      rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_walk_circular();
      test_win();
      test_lose();
      test_bounce();
      test_press_tick();
      test_enable_freeze();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/guess_fsm_multi.md
Name: guess_fsm_multi

Overview:
Parametrised successor to the button-guess game FSM. A one-hot "lit" LED walks across N positions at a programmable rate. The player presses the button matching the lit LED: an exact match scores a win, anything else scores a loss. The block adds selectable walk modes, an input synchroniser with press-edge detection, and saturating win/lose counters. It sits between the board buttons/LEDs and the score display logic.

Parameters:
N, 4, number of buttons/LED positions (N >= 2)
TICK_DIV, 25_000_000, enabled clock cycles per walk step (>= 2)
CNT_W, 8, width of the win/lose score counters

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset (0 = reset)
en  input  1  game enable; 0 freezes walk, tick counter and press detection
mode  input  1  0 = circular walk, 1 = bounce (ping-pong) walk
in  input  N  raw push buttons, asynchronous
y  output  N  LED pattern
win  output  1  high while in WIN state
lose  output  1  high while in LOSE state
win_cnt  output  CNT_W  total wins, saturating
lose_cnt  output  CNT_W  total losses, saturating

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, pos=0, dir=up, tick counter=0, sync flops=0.
  - Outputs during reset: y=1 (one-hot, position 0), win=0, lose=0, win_cnt=0, lose_cnt=0.
- Input path: two-flop synchroniser in -> in_s; in_p = in_s delayed one cycle.
  - press = en & (in_s != 0) & (in_p == 0).
  - Latency: win/lose asserts on the 3rd rising edge after in changes.
- Tick: counter runs only when en=1 and state=RUN. It emits a 1-cycle tick when it reaches TICK_DIV-1, then wraps to 0. It clears on any transition into RUN.
- States:
  - RUN: y = one-hot(pos).
    - press with in_s == y -> WIN, and win_cnt increments.
    - press otherwise (wrong button or multiple buttons) -> LOSE, and lose_cnt increments.
    - tick with no press -> pos advances.
  - WIN: y = all ones, win=1. Stays until in_s == 0, then -> RUN with pos=0, dir=up.
  - LOSE: y = all zeros, lose=1. Same exit rule as WIN.
- Walk, mode 0: pos = pos+1, wrapping N-1 -> 0.
- Walk, mode 1: pos moves in dir and reverses at the ends (…N-2, N-1, N-2 … 1, 0, 1 …). No repeat at the end points.
  - Changing mode mid-game takes effect on the next tick. If mode switches to 0 while dir=down, dir is forced to up.
- Simultaneous press and tick: the press has priority. It is judged against the current y, and pos does not advance.
- en=0 in WIN/LOSE: the state still exits on button release. Counters are unaffected.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset mid-game aborts immediately to the reset values. Counters clear.

Decomposition:
- Package guess_pkg:
  - state_t enum {RUN, WIN, LOSE}.
  - dir_t enum {UP, DOWN}.
- One sub-module, tick_gen: parameter TICK_DIV; ports clk, rst, en, clr, tick. The counter width is derived with $clog2(TICK_DIV).
- The synchroniser, FSM, position/direction logic and counters stay in the top module.

Test Plan (N=4, TICK_DIV=4, CNT_W=2):
1. Reset, then en=1, mode=0, no buttons for 20 cycles -> y steps 0001,0010,0100,1000,0001, one step every 4 cycles; win=lose=0.
2. With y=0100, drive in=0100 -> on the 3rd edge win=1, y=1111, win_cnt=1. Release in -> next cycles y=0001, state RUN.
3. With y=0010, drive in=0011 -> lose=1, y=0000, lose_cnt=1. Hold in for 10 cycles -> stays LOSE. Release -> RUN, y=0001.
4. mode=1, no buttons -> y sequence 0001,0010,0100,1000,0100,0010,0001,0010. Switch to mode=0 while moving down -> next step goes up.
5. Press timed so that press and tick coincide at y=1000 with in=1000 -> WIN; pos did not advance before judgement. Repeat four wins -> win_cnt saturates at 3.
6. en=0 mid-RUN: y frozen and presses ignored. Then pulse rst=0 asynchronously between clock edges -> outputs go immediately to y=0001, counters=0.
